cacheline_adapter: RTL and testbench

CACHELINE_ADAPTER -- requirements
Module: cacheline_adapter

---
 rtl/cacheline_adapter_if.sv | 30 +++
 rtl/cacheline_adapter.sv | 114 +++++++++++
 tb/tb_cacheline_adapter.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/cacheline_adapter_if.sv
// Cache-side and memory-side handshake bundle for cacheline_adapter.
// The bench drives through the master modport; the adapter uses the slave modport.
interface cacheline_adapter_if #(
   parameter int BEATS = 4
) ();
   localparam int LINE_W = 64 * BEATS;

   logic [31:0]       address_i;
   logic [LINE_W-1:0] line_i;
   logic              read_i;
   logic              write_i;
   logic [LINE_W-1:0] line_o;
   logic              resp_o;
   logic [31:0]       address_o;
   logic [63:0]       burst_o;
   logic [63:0]       burst_i;
   logic              read_o;
   logic              write_o;
   logic              resp_i;

   modport master (
      output address_i, line_i, read_i, write_i, burst_i, resp_i,
      input  line_o, resp_o, address_o, burst_o, read_o, write_o
   );

   modport slave (
      input  address_i, line_i, read_i, write_i, burst_i, resp_i,
      output line_o, resp_o, address_o, burst_o, read_o, write_o
   );
endinterface

// File: rtl/cacheline_adapter.sv
// Converts whole cache-line reads/writes into BEATS x 64-bit memory bursts.
// Optional macro CLA_PERF_COUNTERS_EN adds internal read/write/wait counters.
module cacheline_adapter #(
   parameter int BEATS = 4
) (
   input  logic             clk,
   input  logic             rst,
   cacheline_adapter_if.slave bus
);
   localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

   typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

   state_t                 r_state;
   state_t                 w_next;
   logic [CW-1:0]          r_cnt;
   logic [31:5]            r_addr;
   logic [BEATS-1:0][63:0] r_wline;
   logic [BEATS-1:0][63:0] r_rline;
   logic                   w_beat;
   logic                   w_last;
   logic                   w_accept;
   logic                   w_read_o;
   logic                   w_write_o;
   logic                   w_resp_o;

   // A beat only counts while a burst is in flight; strobes in IDLE/DONE are ignored.
   assign w_beat   = bus.resp_i && ((r_state == READ) || (r_state == WRITE));
   assign w_last   = w_beat && (r_cnt == LAST);
   assign w_accept = (r_state == IDLE) && (bus.read_i || bus.write_i);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= IDLE;
      else      r_state <= w_next;
   end

   always_comb begin
      w_next    = r_state;
      w_read_o  = 1'b0;
      w_write_o = 1'b0;
      w_resp_o  = 1'b0;
      case (r_state)
         IDLE: begin
            if (bus.write_i)     w_next = WRITE;
            else if (bus.read_i) w_next = READ;
         end
         READ: begin
            w_read_o = 1'b1;
            if (w_last) w_next = DONE;
         end
         WRITE: begin
            w_write_o = 1'b1;
            if (w_last) w_next = DONE;
         end
         DONE: begin
            w_resp_o = 1'b1;
            w_next   = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt   <= '0;
         r_addr  <= '0;
         r_wline <= '0;
         r_rline <= '0;
      end else begin
         if (w_accept) begin
            r_cnt  <= '0;
            r_addr <= bus.address_i[31:5];
            if (bus.write_i) r_wline <= bus.line_i;
         end
         if (w_beat) begin
            r_cnt <= w_last ? '0 : r_cnt + CW'(1);
            if (r_state == READ) r_rline[r_cnt] <= bus.burst_i;
         end
      end
   end

   assign bus.read_o    = w_read_o;
   assign bus.write_o   = w_write_o;
   assign bus.resp_o    = w_resp_o;
   assign bus.address_o = {r_addr, 5'b0_0000};
   assign bus.burst_o   = (r_state == WRITE) ? r_wline[r_cnt] : 64'd0;
   assign bus.line_o    = r_rline;

`ifdef CLA_PERF_COUNTERS_EN
   logic [31:0] r_num_reads;
   logic [31:0] r_num_writes;
   logic [31:0] r_num_wait;
   logic        r_is_wr;

   // Burst type is remembered at accept time so DONE can be attributed.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_num_reads  <= '0;
         r_num_writes <= '0;
         r_num_wait   <= '0;
         r_is_wr      <= 1'b0;
      end else begin
         if (w_accept) r_is_wr <= bus.write_i;
         if ((r_state == DONE) && !r_is_wr && (r_num_reads != '1))
            r_num_reads <= r_num_reads + 32'd1;
         if ((r_state == DONE) && r_is_wr && (r_num_writes != '1))
            r_num_writes <= r_num_writes + 32'd1;
         if (((r_state == READ) || (r_state == WRITE)) && !bus.resp_i && (r_num_wait != '1))
            r_num_wait <= r_num_wait + 32'd1;
      end
   end
`endif
endmodule

// File: tb/tb_cacheline_adapter.sv
// Directed self-checking bench for cacheline_adapter (BEATS=4).
module tb_cacheline_adapter;
   typedef logic [3:0][63:0] line_t;

   logic clk;
   logic rst_n;
   int   n_pass;
   int   n_total;

   cacheline_adapter_if #(.BEATS(4)) bus ();

   cacheline_adapter #(.BEATS(4)) dut (
      .clk (clk),
      .rst (rst_n),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time expired, required completion");
      $fatal(1, "watchdog");
   end

   line_t A = {64'hA3A3_0000_0000_0003, 64'hA2A2_0000_0000_0002, 64'hA1A1_0000_0000_0001, 64'hA0A0_0000_0000_0000};
   line_t D = {64'hD3D3_1111_2222_3333, 64'hD2D2_4444_5555_6666, 64'hD1D1_7777_8888_9999, 64'hD0D0_AAAA_BBBB_CCCC};
   line_t E = {64'hE3E3_E3E3_E3E3_E3E3, 64'hE2E2_E2E2_E2E2_E2E2, 64'hE1E1_E1E1_E1E1_E1E1, 64'hE0E0_E0E0_E0E0_E0E0};
   line_t B = {64'hB3B3_0000_0000_0000, 64'hB2B2_0000_0000_0000, 64'hB1B1_0000_0000_0001, 64'hB0B0_0000_0000_0000};
   line_t C = {64'hC3C3_0123_4567_89AB, 64'hC2C2_CDEF_0123_4567, 64'hC1C1_89AB_CDEF_0123, 64'hC0C0_4567_89AB_CDEF};
   line_t F = {64'hF3F3_0000_FFFF_0003, 64'hF2F2_0000_FFFF_0002, 64'hF1F1_0000_FFFF_0001, 64'hF0F0_0000_FFFF_0000};
   line_t G = {64'h6363_1234_0000_0003, 64'h6262_1234_0000_0002, 64'h6161_1234_0000_0001, 64'h6060_1234_0000_0000};

   // Drives one burst cycle by cycle from a resp_i pattern and records what the DUT shows.
   task automatic run_burst(input logic wr, input logic rd, input logic [31:0] addr,
                            input line_t wl, input line_t rb, input logic [15:0] pat, input int npat,
                            output int resp_cyc, output int resp_cnt, output int rd_cyc,
                            output int wr_cyc, output line_t wobs, output logic [31:0] aobs);
      int k;
      bit strobe;
      k = 0; resp_cyc = 0; resp_cnt = 0; rd_cyc = 0; wr_cyc = 0; wobs = '0; aobs = '0;
      bus.write_i = wr; bus.read_i = rd; bus.address_i = addr; bus.line_i = wl;
      for (int n = 1; n <= npat + 4; n++) begin
         strobe = (n >= 2) && (n - 2 < npat) && pat[n-2];
         if (n >= 2) begin bus.address_i = ~addr; bus.line_i = ~wl; end
         if (resp_cnt > 0) begin bus.write_i = 1'b0; bus.read_i = 1'b0; end
         if ((n >= 2) && (n - 2 < npat)) begin
            bus.resp_i  = strobe;
            bus.burst_i = (k < 4) ? rb[k] : 64'h0;
         end else begin
            bus.resp_i  = 1'b1;
            bus.burst_i = 64'hBAD0_BAD0_BAD0_BAD0;
         end
         @(negedge clk);
         if (bus.resp_o)  begin resp_cnt++; resp_cyc = n; end
         if (bus.read_o)  rd_cyc++;
         if (bus.write_o) wr_cyc++;
         if (n == 3) aobs = bus.address_o;
         if (strobe && (k < 4)) begin
            if (bus.write_o) wobs[k] = bus.burst_o;
            k++;
         end
         @(posedge clk); #1;
      end
      bus.read_i = 1'b0; bus.write_i = 1'b0; bus.resp_i = 1'b0;
   endtask

   task automatic test_reset();
      #2;
      n_total++; if (bus.read_o !== 1'b0) $display("FAIL reset_read_o: got %b want 0", bus.read_o); else n_pass++;
      n_total++; if (bus.write_o !== 1'b0) $display("FAIL reset_write_o: got %b want 0", bus.write_o); else n_pass++;
      n_total++; if (bus.resp_o !== 1'b0) $display("FAIL reset_resp_o: got %b want 0", bus.resp_o); else n_pass++;
      n_total++; if (bus.address_o !== 32'h0) $display("FAIL reset_address_o: got %h want 0", bus.address_o); else n_pass++;
      n_total++; if (bus.burst_o !== 64'h0) $display("FAIL reset_burst_o: got %h want 0", bus.burst_o); else n_pass++;
      n_total++; if (bus.line_o !== '0) $display("FAIL reset_line_o: got %h want 0", bus.line_o); else n_pass++;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_read();
      int rc, rn, rdc, wrc; line_t wo; logic [31:0] ao;
      run_burst(1'b0, 1'b1, 32'h0000_1234, '0, A, 16'h000F, 4, rc, rn, rdc, wrc, wo, ao);
      n_total++; if (rc !== 6) $display("FAIL read_resp_cycle: got %0d want 6", rc); else n_pass++;
      n_total++; if (rn !== 1) $display("FAIL read_resp_count: got %0d want 1", rn); else n_pass++;
      n_total++; if (ao !== 32'h0000_1220) $display("FAIL read_address_o: got %h want 00001220", ao); else n_pass++;
      n_total++; if (bus.line_o !== A) $display("FAIL read_line_o: got %h want %h", bus.line_o, A); else n_pass++;
      n_total++; if (rdc !== 4) $display("FAIL read_read_o_cycles: got %0d want 4", rdc); else n_pass++;
      n_total++; if (wrc !== 0) $display("FAIL read_write_o_cycles: got %0d want 0", wrc); else n_pass++;
   endtask

   task automatic test_write_gaps();
      int rc, rn, rdc, wrc; line_t wo; logic [31:0] ao;
      // resp_i sequence 1,0,1,0,0,1,1 (bit 0 first)
      run_burst(1'b1, 1'b0, 32'h0000_ABCD, D, '0, 16'h0065, 7, rc, rn, rdc, wrc, wo, ao);
      n_total++; if (wo !== D) $display("FAIL write_burst_o_beats: got %h want %h", wo, D); else n_pass++;
      n_total++; if (rc !== 9) $display("FAIL write_resp_cycle: got %0d want 9", rc); else n_pass++;
      n_total++; if (rn !== 1) $display("FAIL write_resp_count: got %0d want 1", rn); else n_pass++;
      n_total++; if (wrc !== 7) $display("FAIL write_write_o_cycles: got %0d want 7", wrc); else n_pass++;
      n_total++; if (rdc !== 0) $display("FAIL write_read_o_cycles: got %0d want 0", rdc); else n_pass++;
      n_total++; if (ao !== 32'h0000_ABC0) $display("FAIL write_address_o: got %h want 0000abc0", ao); else n_pass++;
      n_total++; if (bus.line_o !== A) $display("FAIL write_line_o_kept: got %h want %h", bus.line_o, A); else n_pass++;
   endtask

   task automatic test_priority();
      int rc, rn, rdc, wrc; line_t wo; logic [31:0] ao;
      run_burst(1'b1, 1'b1, 32'h0000_0040, E, C, 16'h000F, 4, rc, rn, rdc, wrc, wo, ao);
      n_total++; if (wrc !== 4) $display("FAIL prio_write_o_cycles: got %0d want 4", wrc); else n_pass++;
      n_total++; if (rdc !== 0) $display("FAIL prio_read_o_cycles: got %0d want 0", rdc); else n_pass++;
      n_total++; if (wo !== E) $display("FAIL prio_burst_o_beats: got %h want %h", wo, E); else n_pass++;
      n_total++; if (rn !== 1) $display("FAIL prio_resp_count: got %0d want 1", rn); else n_pass++;
      n_total++; if (bus.line_o !== A) $display("FAIL prio_line_o_kept: got %h want %h", bus.line_o, A); else n_pass++;
   endtask

   task automatic test_reset_midburst();
      int rc, rn, rdc, wrc, rsp; line_t wo; logic [31:0] ao;
      bus.read_i = 1'b1; bus.write_i = 1'b0; bus.address_i = 32'h0000_2000; bus.resp_i = 1'b0;
      @(posedge clk); #1;
      for (int b = 0; b < 2; b++) begin
         bus.resp_i = 1'b1; bus.burst_i = B[b];
         @(posedge clk); #1;
      end
      bus.resp_i = 1'b0;
      n_total++; if (bus.line_o[127:0] !== {B[1], B[0]}) $display("FAIL rstmid_partial_line: got %h want %h", bus.line_o[127:0], {B[1], B[0]}); else n_pass++;
      rst_n = 1'b0;
      #1;
      n_total++; if (bus.read_o !== 1'b0) $display("FAIL rstmid_read_o: got %b want 0", bus.read_o); else n_pass++;
      n_total++; if (bus.line_o !== '0) $display("FAIL rstmid_line_o: got %h want 0", bus.line_o); else n_pass++;
      n_total++; if (bus.address_o !== 32'h0) $display("FAIL rstmid_address_o: got %h want 0", bus.address_o); else n_pass++;
      bus.read_i = 1'b0;
      rsp = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (bus.resp_o) rsp++;
      end
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk); if (bus.resp_o) rsp++;
      n_total++; if (rsp !== 0) $display("FAIL rstmid_no_resp: got %0d pulses want 0", rsp); else n_pass++;
      @(posedge clk); #1;
      run_burst(1'b0, 1'b1, 32'h0000_305F, '0, C, 16'h000F, 4, rc, rn, rdc, wrc, wo, ao);
      n_total++; if (bus.line_o !== C) $display("FAIL rstmid_next_line: got %h want %h", bus.line_o, C); else n_pass++;
      n_total++; if (rc !== 6) $display("FAIL rstmid_next_resp_cycle: got %0d want 6", rc); else n_pass++;
      n_total++; if (ao !== 32'h0000_3040) $display("FAIL rstmid_next_address: got %h want 00003040", ao); else n_pass++;
   endtask

   task automatic test_back_to_back();
      int rsp, first_rc, last_rc;
      line_t wo;
      logic rd8, idle_ok;
      rsp = 0; first_rc = 0; last_rc = 0; wo = '0; rd8 = 1'b0; idle_ok = 1'b0;
      for (int n = 1; n <= 13; n++) begin
         bus.write_i   = (n <= 6);
         bus.read_i    = (n >= 7) && (n <= 12);
         bus.address_i = 32'h0000_4000;
         bus.line_i    = F;
         bus.resp_i    = ((n >= 2) && (n <= 5)) || ((n >= 8) && (n <= 11));
         bus.burst_i   = ((n >= 8) && (n <= 11)) ? G[n-8] : 64'h0;
         @(negedge clk);
         if (bus.resp_o) begin
            rsp++;
            if (first_rc == 0) first_rc = n;
            last_rc = n;
         end
         if ((n >= 2) && (n <= 5)) wo[n-2] = bus.burst_o;
         if (n == 7) idle_ok = !bus.read_o && !bus.write_o;
         if (n == 8) rd8 = bus.read_o;
         @(posedge clk); #1;
      end
      bus.read_i = 1'b0; bus.resp_i = 1'b0;
      n_total++; if (rsp !== 2) $display("FAIL b2b_resp_count: got %0d want 2", rsp); else n_pass++;
      n_total++; if (first_rc !== 6) $display("FAIL b2b_write_resp_cycle: got %0d want 6", first_rc); else n_pass++;
      n_total++; if (last_rc !== 12) $display("FAIL b2b_read_resp_cycle: got %0d want 12", last_rc); else n_pass++;
      n_total++; if (idle_ok !== 1'b1) $display("FAIL b2b_idle_gap: got %b want 1", idle_ok); else n_pass++;
      n_total++; if (rd8 !== 1'b1) $display("FAIL b2b_read_started: got %b want 1", rd8); else n_pass++;
      n_total++; if (wo !== F) $display("FAIL b2b_write_beats: got %h want %h", wo, F); else n_pass++;
      n_total++; if (bus.line_o !== G) $display("FAIL b2b_read_line: got %h want %h", bus.line_o, G); else n_pass++;
   endtask

`ifdef CLA_PERF_COUNTERS_EN
   task automatic test_perf_counters();
      int rc, rn, rdc, wrc; line_t wo; logic [31:0] ao;
      rst_n = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;
      @(posedge clk); #1;
      run_burst(1'b0, 1'b1, 32'h100, '0, A, 16'h001D, 5, rc, rn, rdc, wrc, wo, ao);
      run_burst(1'b0, 1'b1, 32'h200, '0, B, 16'h000F, 4, rc, rn, rdc, wrc, wo, ao);
      run_burst(1'b1, 1'b0, 32'h300, D, '0, 16'h0039, 6, rc, rn, rdc, wrc, wo, ao);
      n_total++; if (dut.r_num_reads !== 32'd2) $display("FAIL perf_num_reads: got %0d want 2", dut.r_num_reads); else n_pass++;
      n_total++; if (dut.r_num_writes !== 32'd1) $display("FAIL perf_num_writes: got %0d want 1", dut.r_num_writes); else n_pass++;
      n_total++; if (dut.r_num_wait !== 32'd3) $display("FAIL perf_num_wait: got %0d want 3", dut.r_num_wait); else n_pass++;
   endtask
`endif

   initial begin
      n_pass = 0; n_total = 0;
      rst_n = 1'b0;
      bus.address_i = '0; bus.line_i = '0; bus.read_i = 1'b0; bus.write_i = 1'b0;
      bus.burst_i = '0; bus.resp_i = 1'b0;
      test_reset();
      test_read();
      test_write_gaps();
      test_priority();
      test_reset_midburst();
      test_back_to_back();
`ifdef CLA_PERF_COUNTERS_EN
      test_perf_counters();
`endif
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
